// File: rtl/count_display.sv
// Binary-to-BCD display driver: sequential double-dabble conversion feeding
// a multiplexed three-digit seven-segment display with leading-zero blanking.
module count_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [7:0]    val_q, val_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [2:0]    iter_q, iter_d;
  logic [7:0]    shown_q, shown_d;
  logic [11:0]   disp_bcd_q, disp_bcd_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [19:0]   shifted;
  logic [3:0]    nib;
  logic          blank;
  logic          ref_wrap;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  assign shifted = {adj(bcd_q[11:8]), adj(bcd_q[7:4]),
                    adj(bcd_q[3:0]), bin_q} << 1;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    val_d      = val_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    shown_d    = shown_q;
    disp_bcd_d = disp_bcd_q;
    unique case (state_q)
      S_IDLE: begin
        if (value != shown_q) begin
          bin_d   = value;
          val_d   = value;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d  = shifted[19:8];
        bin_d  = shifted[7:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_bcd_d = bcd_q;
        shown_d    = val_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ref_wrap = (ref_cnt_q == REF_LAST);

  always_comb begin
    ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + RW'(1);
    digit_sel_d = digit_sel_q;
    if (ref_wrap)
      digit_sel_d = (digit_sel_q == 2'd2) ? 2'd0 : digit_sel_q + 2'd1;
  end

  // Leading-zero blanking: tens blanks only if hundreds is also zero.
  always_comb begin
    nib   = disp_bcd_q[3:0];
    blank = 1'b0;
    unique case (digit_sel_q)
      2'd1: begin
        nib   = disp_bcd_q[7:4];
        blank = (disp_bcd_q[11:4] == 8'd0);
      end
      2'd2: begin
        nib   = disp_bcd_q[11:8];
        blank = (disp_bcd_q[11:8] == 4'd0);
      end
      default: begin
        nib   = disp_bcd_q[3:0];
        blank = 1'b0;
      end
    endcase
    seg_d = blank ? 7'd0 : enc(nib);
    an_d  = (ref_cnt_q == '0) ? 3'b000 : (3'b001 << digit_sel_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      val_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      shown_q     <= '0;
      disp_bcd_q  <= '0;
      ref_cnt_q   <= '0;
      digit_sel_q <= '0;
      seg_q       <= '0;
      an_q        <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      val_q       <= val_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      shown_q     <= shown_d;
      disp_bcd_q  <= disp_bcd_d;
      ref_cnt_q   <= ref_cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  // Internal state is active-high; polarity is applied only at the pins.
  assign seg  = COMMON_ANODE ? ~seg_q : seg_q;
  assign an   = COMMON_ANODE ? ~an_q : an_q;
  assign dp   = COMMON_ANODE ? 1'b1 : 1'b0;
  assign busy = (state_q != S_IDLE);

endmodule
